// File: rtl/instr_decode_ctrl.sv
// rtl/instr_decode_ctrl.sv - branch/jump decode and program-state control
//
// Purpose: decodes redirect instructions (JMP, BRZ, BRNZ, HALT) from the
// instruction ROM output and drives same-cycle redirects to the fetch unit.
// It also sequences the program through IDLE/ARM/RUN/HALT.
// Optional feature macro: DECODE_STATS_EN (redirect statistics counter).
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        program load/hold request (shared with fetch_unit)
//   instr_in     instruction at current PC (combinational ROM output)
//   flag_we      execute-stage compare result valid this cycle
//   zero_in      execute-stage compare result (1 = equal/zero)
//   branch_taken relative redirect, combinational
//   branch_imm   signed relative offset, always instr_in[3:0]
//   jump_taken   absolute redirect via LUT, combinational
//   jump_target  LUT index, instr_in[5:0]
//   done         program halted (registered)
//   taken_count  redirect count (0 unless DECODE_STATS_EN)

module instr_decode_ctrl #(
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               flag_we,
  input  logic               zero_in,
  output logic               branch_taken,
  output logic [3:0]         branch_imm,
  output logic               jump_taken,
  output logic [5:0]         jump_target,
  output logic               done,
  output logic [15:0]        taken_count
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, HALT} state_e;

  localparam logic [8:0] HALT_OP = 9'b1_1000_0000;

  state_e state_q, state_d;
  logic   flag_q;
  logic   done_q;
  logic   is_jmp, is_brz, is_brnz, is_halt;
  logic   in_run;

  assign is_jmp  = (instr_in[8:6] == 3'b111);
  assign is_brz  = (instr_in[8:4] == 5'b11010);
  assign is_brnz = (instr_in[8:4] == 5'b11011);
  assign is_halt = (instr_in[8:0] == HALT_OP);
  assign in_run  = (state_q == RUN);

  // Redirects are zero-latency; the branch condition uses only the
  // registered flag, so a compare completing this cycle cannot bypass.
  assign jump_taken   = in_run & is_jmp;
  assign branch_taken = in_run & ((is_brz & flag_q) | (is_brnz & ~flag_q));
  assign jump_target  = instr_in[5:0];
  assign branch_imm   = instr_in[3:0];
  assign done         = done_q;

  // start has priority in RUN so a restart wins over a HALT fetched the
  // same cycle. HALT in ARM is ignored: ARM only looks at start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM:  if (!start) state_d = RUN;
      RUN: begin
        if (start)        state_d = ARM;
        else if (is_halt) state_d = HALT;
      end
      HALT: if (start) state_d = ARM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == HALT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 1'b0;
    end else if (flag_we) begin
      flag_q <= zero_in;
    end
  end

`ifdef DECODE_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Clearing whenever the next state is ARM covers every entry into ARM;
  // nothing counts while in ARM, so holding it at zero there is harmless.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ARM) begin
      cnt_d = 16'h0000;
    end else if (in_run && (branch_taken || jump_taken) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_count = cnt_q;
`else
  assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// tb/tb_instr_decode_ctrl.sv - scoreboard bench for instr_decode_ctrl

module tb_instr_decode_ctrl;

  typedef struct {
    string       name;
    logic        br;
    logic [3:0]  bimm;
    logic        jmp;
    logic [5:0]  jt;
    logic        dn;
    logic [15:0] cnt;
  } exp_t;

  localparam logic [8:0] OP_HALT = 9'b1_1000_0000;
  localparam logic [8:0] OP_NOP  = 9'b0_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  instr_in;
  logic        flag_we;
  logic        zero_in;
  logic        branch_taken;
  logic [3:0]  branch_imm;
  logic        jump_taken;
  logic [5:0]  jump_target;
  logic        done;
  logic [15:0] taken_count;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  instr_decode_ctrl #(.INSTR_W(9)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .instr_in     (instr_in),
    .flag_we      (flag_we),
    .zero_in      (zero_in),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump_taken   (jump_taken),
    .jump_target  (jump_target),
    .done         (done),
    .taken_count  (taken_count)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are sampled on the falling edge, away from the
  // active edge, against whatever the driver queued this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic bad;
      e = sb_q.pop_front();
      n_vec++;
      bad = (branch_taken !== e.br) || (branch_imm !== e.bimm) ||
            (jump_taken !== e.jmp) || (done !== e.dn) ||
            (taken_count !== e.cnt) || (e.jmp && (jump_target !== e.jt));
      if (bad) begin
        n_err++;
        $display("FAIL %s: got br=%0b imm=%h jmp=%0b jt=%0d done=%0b cnt=%h, want br=%0b imm=%h jmp=%0b jt=%0d done=%0b cnt=%h",
                 e.name, branch_taken, branch_imm, jump_taken, jump_target, done, taken_count,
                 e.br, e.bimm, e.jmp, e.jt, e.dn, e.cnt);
      end
    end
  end

  task automatic step(input logic s, input logic [8:0] ins, input logic fwe, input logic z);
    @(posedge clk);
    #1;
    start    = s;
    instr_in = ins;
    flag_we  = fwe;
    zero_in  = z;
  endtask

  // cs is the expected counter value when statistics are built in.
  task automatic expect_out(input string nm, input logic br, input logic jmp,
                            input logic dn, input logic [15:0] cs);
    exp_t e;
    e.name = nm;
    e.br   = br;
    e.bimm = instr_in[3:0];
    e.jmp  = jmp;
    e.jt   = instr_in[5:0];
    e.dn   = dn;
`ifdef DECODE_STATS_EN
    e.cnt  = cs;
`else
    e.cnt  = 16'h0000;
    if (cs == 16'hFFFF) e.cnt = 16'h0000;
`endif
    sb_q.push_back(e);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    instr_in = OP_NOP;
    flag_we  = 1'b0;
    zero_in  = 1'b0;
    #2;
    expect_out("reset_state", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    step(1, 9'b111_001010, 0, 0); expect_out("idle_jmp", 0, 0, 0, 0);
    step(1, 9'b111_001010, 0, 0); expect_out("arm_jmp", 0, 0, 0, 0);
    step(0, OP_HALT, 0, 0);       expect_out("arm_halt_noop", 0, 0, 0, 0);
    step(0, 9'b111_001010, 0, 0); expect_out("run_jmp10", 0, 1, 0, 0);
    step(0, 9'b11010_1110, 1, 1); expect_out("brz_no_bypass", 0, 0, 0, 1);
    step(0, 9'b11010_1110, 0, 0); expect_out("brz_flag1", 1, 0, 0, 1);
    step(0, 9'b11011_0011, 1, 0); expect_out("brnz_flag1", 0, 0, 0, 2);
    step(0, 9'b11011_0011, 0, 0); expect_out("brnz_flag0", 1, 0, 0, 2);
    step(0, 9'b11010_1110, 1, 1); expect_out("brz_flag0", 0, 0, 0, 3);
    step(0, 9'b11010_0101, 0, 0); expect_out("brz_after_we", 1, 0, 0, 3);
    step(0, OP_NOP, 0, 0);        expect_out("nop", 0, 0, 0, 4);
    step(0, OP_HALT, 0, 0);       expect_out("halt_instr", 0, 0, 0, 4);
    step(0, 9'b111_001010, 0, 0); expect_out("halted", 0, 0, 1, 4);
    step(1, 9'b111_001010, 0, 0); expect_out("halt_start", 0, 0, 1, 4);
    step(0, 9'b111_001010, 0, 0); expect_out("rearm", 0, 0, 0, 0);
    step(0, 9'b111_000101, 0, 0); expect_out("run_jmp5", 0, 1, 0, 0);
    step(1, 9'b111_000101, 0, 0); expect_out("restart_req", 0, 1, 0, 1);
    step(0, 9'b111_000101, 0, 0); expect_out("restart_arm", 0, 0, 0, 0);
    step(0, 9'b111_000101, 0, 0); expect_out("run_again", 0, 1, 0, 0);

    // Asynchronous reset mid-RUN: checked before any further clock edge.
    @(posedge clk); #1;
    reset_n = 1'b0;
    expect_out("async_reset", 0, 0, 0, 0);
    step(0, 9'b111_000101, 0, 0);
    reset_n = 1'b1;
    expect_out("post_reset_idle", 0, 0, 0, 0);
    step(1, 9'b11011_0001, 0, 0); expect_out("post_reset_arm", 0, 0, 0, 0);
    step(0, 9'b11011_0001, 0, 0); expect_out("post_reset_arm2", 0, 0, 0, 0);
    step(0, 9'b11011_0001, 0, 0); expect_out("flag_cleared_brnz", 1, 0, 0, 0);
    step(0, 9'b11010_0001, 0, 0); expect_out("flag_cleared_brz", 0, 0, 0, 1);

`ifdef DECODE_STATS_EN
    step(1, OP_NOP, 0, 0);        expect_out("stats_arm", 0, 0, 0, 1);
    step(0, OP_NOP, 0, 0);        expect_out("stats_arm_clear", 0, 0, 0, 0);
    step(0, 9'b111_000001, 0, 0); expect_out("stats_j1", 0, 1, 0, 0);
    step(0, 9'b111_000010, 0, 0); expect_out("stats_j2", 0, 1, 0, 1);
    step(0, 9'b111_000011, 0, 0); expect_out("stats_j3", 0, 1, 0, 2);
    step(0, OP_NOP, 0, 0);        expect_out("stats_count3", 0, 0, 0, 3);
    step(1, OP_NOP, 0, 0);        expect_out("stats_restart", 0, 0, 0, 3);
    step(0, OP_NOP, 0, 0);        expect_out("stats_cleared", 0, 0, 0, 0);
    // 65537 taken jumps drive the counter past its ceiling.
    for (int i = 0; i < 65537; i++) step(0, 9'b111_000111, 0, 0);
    step(0, OP_NOP, 0, 0);        expect_out("stats_saturate", 0, 0, 0, 16'hFFFF);
    step(0, 9'b111_000111, 0, 0); expect_out("stats_sat_jmp", 0, 1, 0, 16'hFFFF);
    step(0, OP_NOP, 0, 0);        expect_out("stats_sat_hold", 0, 0, 0, 16'hFFFF);
`endif

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
